// File: rtl/product_acc_pkg.sv
// rtl/product_acc_pkg.sv - shared state enum and width helpers for the product accumulator
package product_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // The sum of len products of 2n bits can never wrap in this width.
    function automatic int acc_width(input int n, input int len);
        return 2 * n + $clog2(len);
    endfunction

    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/sum_out_slice.sv
// rtl/sum_out_slice.sv - single-entry valid/ready output register with overwrite on handshake
module sum_out_slice
    import product_acc_pkg::*;
#(
    parameter int DATA_W  = 18,
    parameter int COUNT_W = 3
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               load,
    input  logic [DATA_W-1:0]  load_data,
    input  logic [COUNT_W-1:0] load_count,
    input  logic               ready,
    output logic [DATA_W-1:0]  data,
    output logic [COUNT_W-1:0] count,
    output logic               valid
);

    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // A load arriving during the drain handshake keeps HOLD, so frames run back to back.
    always_comb begin
        state_next = state;
        case (state)
            ACC: begin
                if (load) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (load) begin
                    state_next = HOLD;
                end else if (ready) begin
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    // The upstream only loads while ready, so the payload is stable whenever it is stalled.
    always_ff @(posedge clk) begin
        if (Reset) begin
            data  <= '0;
            count <= '0;
        end else if (load) begin
            data  <= load_data;
            count <= load_count;
        end
    end

    assign valid = (state == HOLD);

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - accumulates frames of LEN products into a widened sum
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int N     = 8,
    parameter int LEN   = 4,
    parameter int ACC_W = acc_width(N, LEN),
    parameter int CNT_W = cnt_width(LEN)
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [2*N-1:0]   P_in,
    input  logic             P_valid,
    output logic             P_ready,
    input  logic             Flush,
    output logic [ACC_W-1:0] Sum_out,
    output logic [CNT_W-1:0] Sum_count,
    output logic             Sum_valid,
    input  logic             Sum_ready
);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             close;
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] count_next;

    assign P_ready    = !Sum_valid || Sum_ready;
    assign accept     = P_valid && P_ready;
    assign sum_next   = acc + (accept ? ACC_W'(P_in) : '0);
    assign count_next = cnt + CNT_W'(accept);

    // A Flush with nothing buffered and nothing arriving must not emit an empty frame.
    assign close = (accept && (cnt == CNT_W'(LEN - 1)))
                || (Flush && P_ready && ((cnt != '0) || accept));

    always_ff @(posedge clk) begin
        if (Reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (close) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= sum_next;
            cnt <= count_next;
        end
    end

    sum_out_slice #(
        .DATA_W (ACC_W),
        .COUNT_W(CNT_W)
    ) u_sum_out_slice (
        .clk       (clk),
        .Reset     (Reset),
        .load      (close),
        .load_data (sum_next),
        .load_count(count_next),
        .ready     (Sum_ready),
        .data      (Sum_out),
        .count     (Sum_count),
        .valid     (Sum_valid)
    );

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed scoreboard bench for product_accumulator (N=8, LEN=4)
module tb_product_accumulator;

    localparam int N     = 8;
    localparam int LEN   = 4;
    localparam int ACC_W = 18;
    localparam int CNT_W = 3;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] count;
    } exp_t;

    logic             clk = 1'b0;
    logic             Reset;
    logic [2*N-1:0]   P_in;
    logic             P_valid;
    logic             P_ready;
    logic             Flush;
    logic [ACC_W-1:0] Sum_out;
    logic [CNT_W-1:0] Sum_count;
    logic             Sum_valid;
    logic             Sum_ready;

    exp_t sb[$];
    int   vectors = 0;
    int   fails   = 0;

    always #5 clk = ~clk;

    product_accumulator #(.N(N), .LEN(LEN)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .P_in     (P_in),
        .P_valid  (P_valid),
        .P_ready  (P_ready),
        .Flush    (Flush),
        .Sum_out  (Sum_out),
        .Sum_count(Sum_count),
        .Sum_valid(Sum_valid),
        .Sum_ready(Sum_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int sum, input int count);
        exp_t e;
        e.sum   = ACC_W'(sum);
        e.count = CNT_W'(count);
        sb.push_back(e);
    endtask

    // Drives one cycle; samples at the falling edge, pops the scoreboard on a handshake.
    task automatic cyc(input logic pv, input int p, input logic fl, input logic sr, input logic ep);
        exp_t e;
        P_valid   = pv;
        P_in      = (2*N)'(p);
        Flush     = fl;
        Sum_ready = sr;
        @(negedge clk);
        if (!Reset) chk("p_ready", 32'(P_ready), 32'(ep));
        if (Sum_valid && Sum_ready) begin
            vectors++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL sb_unexpected observed sum=%0d count=%0d expected no output", Sum_out, Sum_count);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sum_out", 32'(Sum_out), 32'(e.sum));
                chk("sum_count", 32'(Sum_count), 32'(e.count));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        P_valid = 1'b0; P_in = '0; Flush = 1'b0; Sum_ready = 1'b1;
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        Reset = 1'b0;
        chk("rst_valid", 32'(Sum_valid), 0);
        chk("rst_sum", 32'(Sum_out), 0);
        chk("rst_count", 32'(Sum_count), 0);
        chk("rst_p_ready", 32'(P_ready), 1);

        // 10+20+30+40
        push(100, 4);
        cyc(1, 10, 0, 1, 1);
        cyc(1, 20, 0, 1, 1);
        cyc(1, 30, 0, 1, 1);
        chk("lat_not_early", 32'(Sum_valid), 0);
        cyc(1, 40, 0, 1, 1);
        chk("lat_valid", 32'(Sum_valid), 1);

        // full-scale products, back-to-back with the previous frame
        push(260100, 4);
        for (int i = 0; i < 4; i++) cyc(1, 65025, 0, 1, 1);
        chk("max_valid", 32'(Sum_valid), 1);

        // stall: output must hold and no product may be taken
        push(10, 4);
        for (int i = 1; i <= 4; i++) cyc(1, i, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 5, 0, 0, 0);
            chk("stall_sum", 32'(Sum_out), 10);
            chk("stall_valid", 32'(Sum_valid), 1);
        end
        push(20, 4);
        for (int i = 0; i < 4; i++) cyc(1, 5, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);

        // early flush, then a flush with an empty frame
        push(16, 2);
        cyc(1, 7, 0, 1, 1);
        cyc(1, 9, 0, 1, 1);
        cyc(0, 0, 1, 1, 1);
        chk("flush_valid", 32'(Sum_valid), 1);
        cyc(0, 0, 1, 1, 1);
        chk("empty_flush", 32'(Sum_valid), 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);

        // flush concurrent with the accepted product
        push(8, 3);
        cyc(1, 1, 0, 1, 1);
        cyc(1, 2, 0, 1, 1);
        cyc(1, 5, 1, 1, 1);
        cyc(0, 0, 0, 1, 1);

        // reset mid-frame discards the partial sum
        cyc(1, 3, 0, 1, 1);
        cyc(1, 3, 0, 1, 1);
        cyc(1, 3, 0, 1, 1);
        Reset = 1'b1;
        cyc(0, 0, 0, 1, 1);
        Reset = 1'b0;
        chk("rst2_valid", 32'(Sum_valid), 0);
        chk("rst2_sum", 32'(Sum_out), 0);
        chk("rst2_count", 32'(Sum_count), 0);
        chk("rst2_p_ready", 32'(P_ready), 1);
        push(4, 4);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
